grid_reader: RTL and testbench
==============================

# grid_reader

Frame readout engine for the life cell grid. On request it snapshots the grid's flat `states` vector and streams it out one cell per valid/ready handshake in row-major display order, with start-of-line, end-of-line and end-of-frame markers. It also reports the frame's live-cell population. It sits between the cell array and any display or host sink, so rendering no longer needs to probe the grid directly.

## Interface
- `WIDTH`, 20, cells per row
- `HEIGHT`, 20, rows per frame
- `POP_W`, 16, population counter width; must satisfy 2^POP_W > WIDTH*HEIGHT

- `clock` in 1: single clock, rising-edge sampled
- `reset_n` in 1: asynchronous, active-low reset
- `states` in WIDTH*HEIGHT: grid cell states; bit `r*WIDTH+c` is row r, column c
- `start` in 1: frame request, honoured only in IDLE
- `busy` out 1: high from snapshot until frame done
- `out_valid` out 1: cell beat available
- `out_ready` in 1: sink accepts beat
- `out_cell` out 1: cell state of current beat
- `out_sol` out 1: beat is column 0
- `out_eol` out 1: beat is column WIDTH-1
- `out_eof` out 1: beat is row HEIGHT-1, column WIDTH-1
- `done` out 1: one-cycle pulse after the last beat is accepted
- `population` out POP_W: live-cell count of the last completed frame

## Operation
- FSM states are IDLE, SEND and DONE.
  - IDLE with `start`=1: copy `states` into the snapshot register, clear `row`, `col` and the running count, then go to SEND.
  - SEND: present beat (`row`,`col`) from the snapshot. On handshake (`out_valid && out_ready`):
    - Add `out_cell` to the running count.
    - If `col`==WIDTH-1: set `col` to 0 and increment `row`; otherwise increment `col`.
    - On the eof beat, go to DONE instead.
  - DONE: one cycle, then return to IDLE unconditionally.
- Beat order: row 0 to HEIGHT-1, and within each row column 0 to WIDTH-1. This matches the top-left-first display scan.
- `out_valid` = (state==SEND).
- `out_cell`, `out_sol`, `out_eol` and `out_eof` are held stable while `out_valid && !out_ready`.
- `busy` = (state != IDLE).
- `start` is ignored in SEND and DONE; it is not queued.
- The snapshot is isolated from the grid, so `states` may change freely during SEND.
- `population` is loaded from the running count (including the eof beat) when entering DONE. It holds until the next DONE, and is not cleared by `start`.
- Degenerate grid WIDTH=1: every beat has `out_sol`=`out_eol`=1.
- Reset (`reset_n`=0, any time, including mid-frame):
  - Immediately forces IDLE.
  - `out_valid`, `busy`, `done`, `out_cell`, `out_sol`, `out_eol`, `out_eof` go to 0.
  - `population`, `row`, `col` and the snapshot go to 0.
  - No partial frame is resumed after reset.

## Timing
- The grid updates `states` on the falling clock edge, so `states` is stable at every rising edge. The snapshot is taken at the rising edge where `start` is accepted (edge k).
- `out_valid`=1 and `busy`=1 from cycle k+1.
- The first beat (row 0, col 0, `out_sol`=1) is presented in cycle k+1.
- With `out_ready` held at 1, one beat transfers per cycle. The eof beat is accepted at edge k+WIDTH*HEIGHT.
- Done sequence after the eof handshake at edge m:
  - Cycle m+1: `done`=1, `population` valid, `out_valid`=0, `busy`=1.
  - Edge m+2: back in IDLE, `busy`=0.
  - The earliest next `start` is accepted at edge m+2.
- Backpressure: each cycle with `out_valid`=1 and `out_ready`=0 adds one cycle; there is no beat loss or duplication.
- `out_ready` is don't-care outside SEND.
- No combinational path from `out_ready` to `out_valid`.

## Test plan
- Use WIDTH=4, HEIGHT=3 for all scenarios.
- Checkerboard: set `states`=12'b1010_0101_1010, pulse `start`, hold `out_ready`=1.
  - Required: 12 beats whose `out_cell` equals bits 0..11 in order.
  - Required: `out_sol` on beats 0,4,8; `out_eol` on beats 3,7,11; `out_eof` only on beat 11.
  - Required: `done` one cycle later with `population`=6.
- Snapshot isolation: start with `states`=12'hFFF, then drive `states`=0 from cycle k+1.
  - Required: all 12 beats have `out_cell`=1 and `population`=12.
- Backpressure: toggle `out_ready` 1,0,0,1,... with pseudo-random stalls.
  - Required: payload is stable during stalls, sequence identical to the checkerboard case, and total cycles = 12 + stall count.
- Start while busy: pulse `start` at beat 5 and again in the DONE cycle.
  - Required: both pulses ignored, exactly one frame emitted, and `busy` falls 2 cycles after the eof beat is accepted.
- Reset mid-frame: assert `reset_n`=0 asynchronously after beat 6.
  - Required: all outputs 0 with no clock edge needed, and `population`=0.
  - Then release reset and start with `states`=12'h001. Required: the first beat is `out_cell`=1 and `population`=1.
- Empty grid: `states`=0.
  - Required: `population`=0 and `done` pulses exactly once.

Source files
------------

// File: rtl/grid_reader.sv
// grid_reader: snapshots the flat cell-state vector on request and streams it
// out one cell per valid/ready beat in row-major order, with line/frame
// markers and a live-cell population count for the completed frame.
module grid_reader #(
  parameter int WIDTH  = 20,
  parameter int HEIGHT = 20,
  parameter int POP_W  = 16
) (
  input  logic                      clock,
  input  logic                      reset_n,
  input  logic [WIDTH*HEIGHT-1:0]   states,
  input  logic                      start,
  output logic                      busy,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic                      out_cell,
  output logic                      out_sol,
  output logic                      out_eol,
  output logic                      out_eof,
  output logic                      done,
  output logic [POP_W-1:0]          population
);

  localparam int N     = WIDTH * HEIGHT;
  localparam int IDX_W = (N > 1)      ? $clog2(N)      : 1;
  localparam int COL_W = (WIDTH > 1)  ? $clog2(WIDTH)  : 1;
  localparam int ROW_W = (HEIGHT > 1) ? $clog2(HEIGHT) : 1;

  localparam logic [COL_W-1:0] COL_LAST = COL_W'(WIDTH - 1);
  localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(HEIGHT - 1);

  typedef enum logic [1:0] {IDLE = 2'd0, SEND = 2'd1, DONE = 2'd2} state_t;

  state_t             state, state_nx;
  logic [N-1:0]       snap;
  logic [ROW_W-1:0]   row;
  logic [COL_W-1:0]   col;
  // Linear index tracks row*WIDTH+col so the cell select needs no multiplier.
  logic [IDX_W-1:0]   idx;
  logic [POP_W-1:0]   cnt;

  logic send, fire, last_col, last_row, cur;

  assign send     = (state == SEND);
  assign fire     = send && out_ready;
  assign last_col = (col == COL_LAST);
  assign last_row = (row == ROW_LAST);
  assign cur      = snap[idx];

  // Beat payload comes straight from registers, so it is stable under stalls
  // and out_valid depends only on state (no path from out_ready).
  assign out_valid = send;
  assign out_cell  = send & cur;
  assign out_sol   = send & (col == '0);
  assign out_eol   = send & last_col;
  assign out_eof   = send & last_col & last_row;
  assign done      = (state == DONE);
  assign busy      = (state != IDLE);

  // State register.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_nx;
  end

  // Next-state logic: start only honoured in IDLE; DONE lasts one cycle.
  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:    if (start) state_nx = SEND;
      SEND:    if (fire && last_col && last_row) state_nx = DONE;
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Snapshot capture, scan position and running live-cell count.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      snap <= '0;
      row  <= '0;
      col  <= '0;
      idx  <= '0;
      cnt  <= '0;
    end else if (state == IDLE && start) begin
      snap <= states;
      row  <= '0;
      col  <= '0;
      idx  <= '0;
      cnt  <= '0;
    end else if (fire) begin
      cnt <= cnt + POP_W'(cur);
      idx <= idx + IDX_W'(1);
      if (last_col) begin
        col <= '0;
        row <= row + ROW_W'(1);
      end else begin
        col <= col + COL_W'(1);
      end
    end
  end

  // Population publishes the full count, eof beat included, entering DONE.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n)                           population <= '0;
    else if (fire && last_col && last_row)  population <= cnt + POP_W'(cur);
  end

endmodule

// File: tb/tb_grid_reader.sv
// tb_grid_reader: randomized frames on a 4x3 grid checked against a simple
// reference (expected beat i is bit i of the requested grid; population is
// its popcount).
module tb_grid_reader;
  localparam int W = 4;
  localparam int H = 3;
  localparam int N = W * H;

  logic          clock = 1'b0;
  logic          reset_n = 1'b0;
  logic [N-1:0]  states = '0;
  logic          start = 1'b0;
  logic          out_ready = 1'b0;
  logic          busy, out_valid, out_cell, out_sol, out_eol, out_eof, done;
  logic [15:0]   population;

  int n_cmp = 0;
  int n_bad = 0;

  grid_reader #(.WIDTH(W), .HEIGHT(H), .POP_W(16)) dut (
    .clock(clock), .reset_n(reset_n), .states(states), .start(start),
    .busy(busy), .out_valid(out_valid), .out_ready(out_ready),
    .out_cell(out_cell), .out_sol(out_sol), .out_eol(out_eol),
    .out_eof(out_eof), .done(done), .population(population)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int popcnt(input logic [N-1:0] v);
    int p = 0;
    for (int i = 0; i < N; i++) p += int'(v[i]);
    return p;
  endfunction

  // One full frame. stall_pct: chance of out_ready=0 per beat cycle.
  // iso: zero the grid input right after the snapshot edge.
  // sbusy: pulse start at beat 5 and in the DONE cycle.
  task automatic run_frame(input logic [N-1:0] st, input int stall_pct,
                           input bit iso, input bit sbusy);
    int b = 0, cyc = 0, stalls = 0, pop;
    logic [3:0] held = '0;
    bit was_stall = 0, rdy;
    pop = popcnt(st);
    @(negedge clock);
    chk("idle_busy", busy, 0);
    states = st;
    start  = 1'b1;
    out_ready = 1'($urandom_range(1));
    @(negedge clock);   // cycle k+1
    start = 1'b0;
    if (iso) states = '0;
    while (b < N && cyc < 200) begin
      cyc++;
      chk("valid", out_valid, 1);
      chk("busy", busy, 1);
      chk("done_mid", done, 0);
      chk("cell", out_cell, st[b]);
      chk("sol", out_sol, (b % W) == 0);
      chk("eol", out_eol, (b % W) == W - 1);
      chk("eof", out_eof, b == N - 1);
      if (was_stall) chk("stall_hold", {out_cell, out_sol, out_eol, out_eof}, held);
      held  = {out_cell, out_sol, out_eol, out_eof};
      start = sbusy && (b == 5);
      rdy   = ($urandom_range(99) >= stall_pct);
      out_ready = rdy;
      if (rdy) b++; else stalls++;
      was_stall = !rdy;
      @(negedge clock);
    end
    chk("beats_timeout", b, N);
    chk("frame_cycles", cyc, N + stalls);
    // cycle m+1: DONE
    chk("done", done, 1);
    chk("done_valid", out_valid, 0);
    chk("done_busy", busy, 1);
    chk("population", population, pop);
    start = sbusy;
    out_ready = 1'($urandom_range(1));
    @(negedge clock);   // cycle m+2: IDLE
    start = 1'b0;
    chk("post_done", done, 0);
    chk("post_busy", busy, 0);
    chk("post_valid", out_valid, 0);
    @(negedge clock);
    chk("no_queue_busy", busy, 0);
    chk("pop_hold", population, pop);
  endtask

  initial begin
    logic [N-1:0] r;
    #2;
    chk("rst_busy", busy, 0);
    chk("rst_valid", out_valid, 0);
    chk("rst_pop", population, 0);
    @(negedge clock);
    reset_n = 1'b1;

    run_frame(12'b1010_0101_1010, 0, 0, 0);    // checkerboard
    run_frame(12'hFFF, 0, 1, 0);               // snapshot isolation
    run_frame(12'b1010_0101_1010, 40, 0, 0);   // backpressure
    run_frame(12'b1010_0101_1010, 0, 0, 1);    // start while busy
    for (int i = 0; i < 6; i++) begin
      r = N'($urandom);
      run_frame(r, 30, 1'($urandom_range(1)), 1'($urandom_range(1)));
    end

    // Reset mid-frame after beat 6 has been accepted.
    @(negedge clock);
    states = 12'hFFF;
    start = 1'b1;
    out_ready = 1'b1;
    @(negedge clock);
    start = 1'b0;
    for (int i = 0; i < 7; i++) @(negedge clock);
    chk("pre_rst_valid", out_valid, 1);
    #2 reset_n = 1'b0;
    #1;
    chk("arst_valid", out_valid, 0);
    chk("arst_busy", busy, 0);
    chk("arst_done", done, 0);
    chk("arst_payload", {out_cell, out_sol, out_eol, out_eof}, 0);
    chk("arst_pop", population, 0);
    @(negedge clock);
    reset_n = 1'b1;
    @(negedge clock);
    chk("post_rst_idle", busy, 0);
    run_frame(12'h001, 0, 0, 0);

    run_frame(12'h000, 20, 0, 0);              // empty grid

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
